// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter that shares one cacheline adaptor
// between the L1 instruction cache (line reads) and the L1 data cache
// (line reads and writebacks). The winning request is latched at grant
// time. All adaptor-side and client-side controls come from registers.
module cache_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  icache_read_i,
  input  logic [ADDR_WIDTH-1:0] icache_address_i,
  output logic [LINE_WIDTH-1:0] icache_line_o,
  output logic                  icache_resp_o,

  input  logic                  dcache_read_i,
  input  logic                  dcache_write_i,
  input  logic [ADDR_WIDTH-1:0] dcache_address_i,
  input  logic [LINE_WIDTH-1:0] dcache_line_i,
  output logic [LINE_WIDTH-1:0] dcache_line_o,
  output logic                  dcache_resp_o,

  output logic [ADDR_WIDTH-1:0] adapt_address_o,
  output logic [LINE_WIDTH-1:0] adapt_line_o,
  input  logic [LINE_WIDTH-1:0] adapt_line_i,
  output logic                  adapt_read_o,
  output logic                  adapt_write_o,
  input  logic                  adapt_resp_i
);

  // Owner encoding shared by the grant logic and last_grant.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [LINE_WIDTH-1:0] LINE_ZERO = {LINE_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  // Keeps the line-number bits and clears the byte offset within the line.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Line-aligns an address so the adaptor always sees a whole-line request.
  function automatic logic [ADDR_WIDTH-1:0] align_line(input logic [ADDR_WIDTH-1:0] addr);
    return addr & LINE_MASK;
  endfunction

  // State and latched transaction.
  state_e                  state_q;
  logic                    owner_q;
  logic                    last_grant_q;
  logic                    op_write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wline_q;
  logic [LINE_WIDTH-1:0]   ret_line_q;

  // Registered outputs.
  logic                    adapt_read_q;
  logic                    adapt_write_q;
  logic                    icache_resp_q;
  logic                    dcache_resp_q;

  // Arbitration decision for the current IDLE cycle.
  logic                    i_req_s;
  logic                    d_req_s;
  logic                    grant_valid_d;
  logic                    grant_owner_d;
  logic                    grant_write_d;
  logic [ADDR_WIDTH-1:0]   grant_addr_d;
  logic [LINE_WIDTH-1:0]   grant_line_d;

  assign i_req_s = icache_read_i;
  assign d_req_s = dcache_read_i | dcache_write_i;

  // Round-robin pick: a lone requester wins; on a tie, whoever was not granted last wins.
  always_comb begin
    grant_valid_d = 1'b0;
    grant_owner_d = OWN_I;
    if (i_req_s && d_req_s) begin
      grant_valid_d = 1'b1;
      grant_owner_d = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req_s) begin
      grant_valid_d = 1'b1;
      grant_owner_d = OWN_I;
    end else if (d_req_s) begin
      grant_valid_d = 1'b1;
      grant_owner_d = OWN_D;
    end else begin
      grant_valid_d = 1'b0;
      grant_owner_d = OWN_I;
    end
  end

  // Operation, aligned address and writeback data of the would-be winner.
  always_comb begin
    grant_write_d = 1'b0;
    grant_addr_d  = ADDR_ZERO;
    grant_line_d  = wline_q;
    if (grant_owner_d == OWN_D) begin
      // A writeback takes priority if the D-cache raises both read and write.
      grant_write_d = dcache_write_i;
      grant_addr_d  = align_line(dcache_address_i);
    end else begin
      grant_write_d = 1'b0;
      grant_addr_d  = align_line(icache_address_i);
    end
    if (grant_write_d) begin
      grant_line_d = dcache_line_i;
    end else begin
      grant_line_d = wline_q;
    end
  end

  // Transaction FSM: grant in IDLE, wait for the adaptor in BUSY, pulse the
  // owner in RESP, and sit in DRAIN until a lingering adaptor response clears.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_I;
      last_grant_q  <= OWN_D;
      op_write_q    <= 1'b0;
      addr_q        <= ADDR_ZERO;
      wline_q       <= LINE_ZERO;
      ret_line_q    <= LINE_ZERO;
      adapt_read_q  <= 1'b0;
      adapt_write_q <= 1'b0;
      icache_resp_q <= 1'b0;
      dcache_resp_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
          if (grant_valid_d) begin
            owner_q       <= grant_owner_d;
            last_grant_q  <= grant_owner_d;
            op_write_q    <= grant_write_d;
            addr_q        <= grant_addr_d;
            wline_q       <= grant_line_d;
            adapt_read_q  <= ~grant_write_d;
            adapt_write_q <= grant_write_d;
            state_q       <= ST_BUSY;
          end else begin
            adapt_read_q  <= 1'b0;
            adapt_write_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end

        ST_BUSY: begin
          // Client inputs are deliberately ignored here.
          if (adapt_resp_i) begin
            if (!op_write_q) begin
              ret_line_q <= adapt_line_i;
            end else begin
              ret_line_q <= ret_line_q;
            end
            adapt_read_q  <= 1'b0;
            adapt_write_q <= 1'b0;
            icache_resp_q <= (owner_q == OWN_I);
            dcache_resp_q <= (owner_q == OWN_D);
            state_q       <= ST_RESP;
          end else begin
            state_q <= ST_BUSY;
          end
        end

        ST_RESP: begin
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
          adapt_read_q  <= 1'b0;
          adapt_write_q <= 1'b0;
          if (adapt_resp_i) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          // The adaptor's done-state response must not complete the next transaction.
          adapt_read_q  <= 1'b0;
          adapt_write_q <= 1'b0;
          if (!adapt_resp_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end

        default: begin
          adapt_read_q  <= 1'b0;
          adapt_write_q <= 1'b0;
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign adapt_read_o    = adapt_read_q;
  assign adapt_write_o   = adapt_write_q;
  assign adapt_address_o = addr_q;
  assign adapt_line_o    = wline_q;
  assign icache_resp_o   = icache_resp_q;
  assign dcache_resp_o   = dcache_resp_q;
  assign icache_line_o   = ret_line_q;
  assign dcache_line_o   = ret_line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: rounds of client requests are turned
// into an expected grant order and pushed into queues. A monitor checks
// every adaptor request and every client response against those queues.
// An adaptor model answers with random latency and response hold time.
module tb_cache_arbiter;

  logic         clk;
  logic         reset_n;
  logic         icache_read_i;
  logic [31:0]  icache_address_i;
  logic [255:0] icache_line_o;
  logic         icache_resp_o;
  logic         dcache_read_i;
  logic         dcache_write_i;
  logic [31:0]  dcache_address_i;
  logic [255:0] dcache_line_i;
  logic [255:0] dcache_line_o;
  logic         dcache_resp_o;
  logic [31:0]  adapt_address_o;
  logic [255:0] adapt_line_o;
  logic [255:0] adapt_line_i;
  logic         adapt_read_o;
  logic         adapt_write_o;
  logic         adapt_resp_i;

  cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .OFFSET_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_read_i(icache_read_i), .icache_address_i(icache_address_i),
    .icache_line_o(icache_line_o), .icache_resp_o(icache_resp_o),
    .dcache_read_i(dcache_read_i), .dcache_write_i(dcache_write_i),
    .dcache_address_i(dcache_address_i), .dcache_line_i(dcache_line_i),
    .dcache_line_o(dcache_line_o), .dcache_resp_o(dcache_resp_o),
    .adapt_address_o(adapt_address_o), .adapt_line_o(adapt_line_o),
    .adapt_line_i(adapt_line_i), .adapt_read_o(adapt_read_o),
    .adapt_write_o(adapt_write_o), .adapt_resp_i(adapt_resp_i)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [255:0] wline; } req_t;
  typedef struct { logic owner; logic [255:0] line; } rsp_t;

  req_t         exp_req_q[$];
  rsp_t         exp_rsp_q[$];
  logic [255:0] data_q[$];

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           rsp_cyc = 0;
  int           lat_force = -1;
  int           hold_force = -1;
  bit           adapt_busy = 1'b0;
  bit           chk_issue = 1'b0;
  bit           fix_en = 1'b0;
  logic [31:0]  fix_addr;
  logic [255:0] fix_line;
  logic [255:0] fix_rdata;

  // Reference state: contents of the shared return line and the last granted client (0=I, 1=D).
  logic [255:0] ret_m = '0;
  logic         last_m = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Record one transaction in grant order.
  task automatic push_exp(input logic owner, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rdata);
    req_t q;
    rsp_t r;
    q.wr = wr;
    q.addr = {addr[31:5], 5'b0};
    q.wline = wline;
    exp_req_q.push_back(q);
    if (!wr) ret_m = rdata;
    r.owner = owner;
    r.line = ret_m;
    exp_rsp_q.push_back(r);
    data_q.push_back(rdata);
    last_m = owner;
  endtask

  // Adaptor model: answers each new request after a latency, holding resp for a while.
  initial begin
    logic [255:0] d;
    int lat, hold;
    bit aborted;
    adapt_resp_i = 1'b0;
    adapt_line_i = '0;
    forever begin
      @(negedge clk);
      if (!reset_n && (adapt_read_o || adapt_write_o)) begin
        adapt_busy = 1'b1;
        if (data_q.size() == 0) begin
          check("adapt_data_avail", 256'd0, 256'd1);
          d = '0;
        end else begin
          d = data_q.pop_front();
        end
        lat = (lat_force >= 0) ? lat_force : int'($urandom_range(4, 0));
        hold = (hold_force >= 1) ? hold_force : int'($urandom_range(4, 1));
        aborted = 1'b0;
        for (int k = 0; k < lat && !aborted; k++) begin
          @(negedge clk);
          if (reset_n) aborted = 1'b1;
        end
        if (!aborted) begin
          adapt_resp_i = 1'b1;
          adapt_line_i = d;
          rsp_cyc = cyc;
          for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            check("quiet_after_resp", {254'd0, adapt_write_o, adapt_read_o}, 256'd0);
          end
          adapt_resp_i = 1'b0;
          adapt_line_i = rand256();
        end
        adapt_busy = 1'b0;
      end
    end
  end

  // Monitor: compares each new adaptor request and each client response with the scoreboard.
  logic [1:0] rw_prev = 2'b00;
  always @(negedge clk) begin
    automatic logic [1:0] rw_now = {adapt_write_o, adapt_read_o};
    automatic req_t q;
    automatic rsp_t r;
    if (rw_now != 2'b00 && rw_prev == 2'b00) begin
      if (exp_req_q.size() == 0) begin
        check("req_unexpected", {254'd0, rw_now}, 256'd0);
      end else begin
        q = exp_req_q.pop_front();
        check("req_op", {254'd0, rw_now}, q.wr ? 256'd2 : 256'd1);
        check("req_addr", {224'd0, adapt_address_o}, {224'd0, q.addr});
        if (q.wr) check("req_line", adapt_line_o, q.wline);
      end
    end
    rw_prev <= rw_now;
    if (icache_resp_o || dcache_resp_o) begin
      if (exp_rsp_q.size() == 0) begin
        check("rsp_unexpected", {254'd0, dcache_resp_o, icache_resp_o}, 256'd0);
      end else begin
        r = exp_rsp_q.pop_front();
        check("rsp_owner", {254'd0, dcache_resp_o, icache_resp_o}, r.owner ? 256'd2 : 256'd1);
        check("rsp_line", r.owner ? dcache_line_o : icache_line_o, r.line);
        check("rsp_latency", 256'(cyc), 256'(rsp_cyc + 1));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_resp", {254'd0, dcache_resp_o, icache_resp_o}, 256'd0);
    check("rst_rw", {254'd0, adapt_write_o, adapt_read_o}, 256'd0);
    check("rst_addr", {224'd0, adapt_address_o}, 256'd0);
    check("rst_adapt_line", adapt_line_o, 256'd0);
    check("rst_ret_line", icache_line_o | dcache_line_o, 256'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b0;
    ret_m = '0;
    last_m = 1'b1;
  endtask

  // One round: I issues n_i reads, D issues n_d ops (dop: 0 read, 1 write, 2 both, -1 random).
  task automatic run_round(input int n_i, input int n_d, input int dop_force);
    logic [31:0] ia[4];
    logic [31:0] da[4];
    logic [255:0] dl[4];
    int dop[4];
    int ri = 0, rd = 0;
    bit pick, first = 1'b1;
    logic [255:0] rdata;
    for (int k = 0; k < n_i; k++) ia[k] = (fix_en && k == 0) ? fix_addr : $urandom();
    for (int k = 0; k < n_d; k++) begin
      da[k] = (fix_en && k == 0) ? fix_addr : $urandom();
      dl[k] = (fix_en && k == 0) ? fix_line : rand256();
      dop[k] = (dop_force >= 0) ? dop_force : int'($urandom_range(2, 0));
    end
    // Expected grant order: a contended grant goes to whoever was not served last.
    while (ri < n_i || rd < n_d) begin
      if (ri < n_i && rd < n_d) pick = ~last_m;
      else pick = (rd < n_d);
      rdata = (fix_en && first) ? fix_rdata : rand256();
      first = 1'b0;
      if (!pick) begin
        push_exp(1'b0, 1'b0, ia[ri], '0, rdata);
        ri++;
      end else begin
        push_exp(1'b1, dop[rd] != 0, da[rd], dl[rd], rdata);
        rd++;
      end
    end
    fork
      begin
        bit got;
        for (int k = 0; k < n_i; k++) begin
          icache_address_i = ia[k];
          icache_read_i = 1'b1;
          got = 1'b0;
          for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (chk_issue && k == 0 && t == 0) begin
              check("issue_latency", {255'd0, adapt_read_o}, 256'd1);
              check("issue_addr", {224'd0, adapt_address_o}, {224'd0, fix_addr[31:5], 5'b0});
            end
            if (icache_resp_o) got = 1'b1;
          end
          check("i_resp_seen", {255'd0, got}, 256'd1);
          icache_read_i = 1'b0;
          @(negedge clk);
        end
      end
      begin
        bit got;
        for (int k = 0; k < n_d; k++) begin
          dcache_address_i = da[k];
          dcache_line_i = dl[k];
          dcache_read_i = (dop[k] != 1);
          dcache_write_i = (dop[k] != 0);
          got = 1'b0;
          for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (dcache_resp_o) got = 1'b1;
          end
          check("d_resp_seen", {255'd0, got}, 256'd1);
          dcache_read_i = 1'b0;
          dcache_write_i = 1'b0;
          dcache_line_i = rand256();
          @(negedge clk);
        end
      end
    join
    for (int t = 0; t < 100 && (exp_rsp_q.size() != 0 || adapt_busy); t++) @(negedge clk);
    check("round_drained", {255'd0, exp_rsp_q.size() == 0 && exp_req_q.size() == 0}, 256'd1);
    exp_req_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bit got;
    reset_n = 1'b1;
    icache_read_i = 1'b0;
    icache_address_i = '0;
    dcache_read_i = 1'b0;
    dcache_write_i = 1'b0;
    dcache_address_i = '0;
    dcache_line_i = '0;
    do_reset();
    repeat (2) @(negedge clk);

    // Lone I read, adaptor answers four cycles after the request appears.
    fix_en = 1'b1; fix_addr = 32'h0000_1234; fix_rdata = {32{8'hAA}};
    chk_issue = 1'b1; lat_force = 4; hold_force = 1;
    run_round(1, 0, 0);
    chk_issue = 1'b0; lat_force = -1; hold_force = -1;

    // Lone D writeback: return line must still hold the previous read data.
    fix_addr = 32'h8000_0040; fix_line = {4{64'h0123_4567_89AB_CDEF}}; fix_rdata = rand256();
    run_round(0, 1, 1);
    fix_en = 1'b0;

    // Contention straight after reset: I first, then alternation.
    do_reset();
    run_round(2, 2, 0);

    // Long adaptor response hold with a pending D request.
    hold_force = 4;
    run_round(1, 1, -1);
    hold_force = -1;

    // D asserts read and write together: the write is issued.
    run_round(0, 1, 2);

    // Reset while the adaptor is still working on a read.
    lat_force = 30;
    a = $urandom();
    push_exp(1'b0, 1'b0, a, '0, rand256());
    icache_address_i = a;
    icache_read_i = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (adapt_read_o) got = 1'b1;
    end
    check("busy_before_reset", {255'd0, got}, 256'd1);
    repeat (2) @(negedge clk);
    icache_read_i = 1'b0;
    do_reset();
    exp_req_q.delete();
    exp_rsp_q.delete();
    lat_force = -1;
    for (int t = 0; t < 40 && adapt_busy; t++) @(negedge clk);
    run_round(1, 0, 0);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      int ni, nd;
      ni = $urandom_range(3, 0);
      nd = $urandom_range(3, 0);
      if (ni == 0 && nd == 0) ni = 1;
      run_round(ni, nd, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-client line-granularity arbiter between the L1 instruction cache, the L1 data cache and the single cacheline adaptor feeding physical memory. Each client issues 256-bit line reads (I-cache) or line reads/writebacks (D-cache). The block grants one client at a time with round-robin fairness, registers the winning request, and drives the adaptor's LLC-side port. It returns the adaptor's response and read line to the granted client only.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width.
- LINE_WIDTH, 256, cache line width.
- OFFSET_BITS, 5, byte-offset bits forced to zero on the downstream address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-high reset (asserted = 1, despite the suffix).
- icache_read_i  in  1  I-cache line read request.
- icache_address_i  in  ADDR_WIDTH  I-cache request address.
- icache_line_o  out  LINE_WIDTH  line returned to I-cache.
- icache_resp_o  out  1  I-cache completion pulse.
- dcache_read_i  in  1  D-cache line read request.
- dcache_write_i  in  1  D-cache line writeback request.
- dcache_address_i  in  ADDR_WIDTH  D-cache request address.
- dcache_line_i  in  LINE_WIDTH  D-cache writeback data.
- dcache_line_o  out  LINE_WIDTH  line returned to D-cache.
- dcache_resp_o  out  1  D-cache completion pulse.
- adapt_address_o  out  ADDR_WIDTH  line-aligned address to adaptor.
- adapt_line_o  out  LINE_WIDTH  writeback data to adaptor.
- adapt_line_i  in  LINE_WIDTH  read line from adaptor.
- adapt_read_o  out  1  adaptor read request.
- adapt_write_o  out  1  adaptor write request.
- adapt_resp_i  in  1  adaptor completion; may stay high several cycles.

## Operation
- States: IDLE, BUSY, RESP, DRAIN.
- IDLE:
  - Requests are sampled.
  - I request = icache_read_i. D request = dcache_read_i | dcache_write_i.
  - If only one client requests, grant it.
  - If both request, grant the client not recorded in last_grant.
  - On grant, latch the following, update last_grant, and go to BUSY:
    - owner;
    - op (write if dcache_write_i, else read; write wins if D asserts both);
    - address as {addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'b0};
    - dcache_line_i, for writes.
- BUSY:
  - adapt_read_o or adapt_write_o = latched op.
  - adapt_address_o and adapt_line_o = latched values.
  - Client inputs are ignored; a request dropped mid-transaction still completes.
  - When adapt_resp_i = 1: capture adapt_line_i into the return register (reads only) and go to RESP.
- RESP:
  - Owner's resp_o = 1 for exactly this cycle. Non-owner resp_o = 0.
  - adapt_read_o and adapt_write_o = 0.
  - If adapt_resp_i = 1, go to DRAIN; else go to IDLE.
- DRAIN:
  - Requests to the adaptor stay low.
  - Go to IDLE when adapt_resp_i = 0.
  - This prevents the adaptor's lingering done-state response from being credited to the next transaction.
- Return lines:
  - icache_line_o and dcache_line_o both drive the shared return register.
  - The register changes only on a read capture.
  - Write completions leave it unchanged.
- Reset (any state, including mid-BUSY):
  - Next cycle: IDLE.
  - All resp, read and write outputs = 0; address, line outputs and return register = 0.
  - last_grant = D, so the first tie goes to I.
  - An in-flight adaptor transaction is abandoned; the adaptor is reset by the same signal.

## Timing
- Request sampled in IDLE at cycle 0 → adapt_read_o/adapt_write_o high at cycle 1. Outputs are registered; there is no combinational input-to-adaptor path.
- adapt_resp_i first high at cycle N in BUSY → client resp_o and valid line at cycle N+1.
- Clients must deassert their request in the cycle after resp_o. A request still high in IDLE is treated as a new request.
- Minimum gap between consecutive grants: RESP plus ≥0 DRAIN cycles, then 1 IDLE cycle.
- Round robin guarantees that, under continuous contention, a waiting client is served at the next grant.

## Test plan
- I-cache read 0x0000_1234 alone; adaptor answers at cycle 5 with line 0xAA..AA:
  - adapt_address_o = 0x0000_1220 and adapt_read_o high from cycle 1;
  - icache_resp_o high only at cycle 6 with icache_line_o = 0xAA..AA;
  - dcache_resp_o stays 0.
- D-cache writeback 0x8000_0040 with line 0x0123…:
  - adapt_write_o high and adapt_line_o = 0x0123…;
  - dcache_resp_o pulses once;
  - dcache_line_o is unchanged from its prior value.
- Simultaneous I read and D read right after reset → I granted first, then D. Both held high continuously → grants alternate I, D, I, D.
- adapt_resp_i held high 3 cycles after completion:
  - exactly one resp_o pulse;
  - FSM waits in DRAIN;
  - a pending D request is granted only after adapt_resp_i falls.
- dcache_read_i and dcache_write_i both high → write issued (adapt_write_o = 1, adapt_read_o = 0).
- reset_n asserted during BUSY → next cycle all outputs 0. A subsequent I request completes normally.
